// File: rtl/cordic_phase_gen.sv
// NCO phase feeder for cordic_pipe: accumulates phase, folds it into [-pi/2, pi/2], scales to Q4.20 radians.
// Optional build macro CORDIC_PHASE_DITHER_EN adds LFSR dither to each sampled phase.
module cordic_phase_gen #(
   parameter int DEPTH  = 8,
   parameter int TWO_PI = 6588397
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [23:0] freq,
   input  logic [23:0] phase_init,
   input  logic        phase_load,
   output logic [23:0] angle,
   output logic        data_loaded,
   input  logic        data_computed,
   output logic        neg_x,
   output logic        tag_valid,
   output logic        tag_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic signed [47:0] TWO_PI_S = 48'(TWO_PI);

   logic [23:0]      acc_reg;
   logic [23:0]      acc_next;
   logic [CNT_W-1:0] outstanding_reg;
   logic [CNT_W-1:0] outstanding_next;
   logic             accept;
   logic             pop;
   logic             push;
   logic [23:0]      sample_phase;
   logic             fold;
   logic [23:0]      r_next;

   logic             s1_valid_reg;
   logic [23:0]      s1_r_reg;
   logic             s1_nx_reg;
   logic signed [47:0] prod;
   logic             prod_lo_unused;

   logic [23:0]      angle_reg;
   logic             data_loaded_reg;
   logic             tag_err_reg;

   logic             tag_mem [DEPTH];
   logic [DEPTH-1:0] tag_we;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Credits are reserved at accept time, so the tag FIFO can never overflow.
   assign accept = en & ~phase_load & (outstanding_reg < CNT_W'(DEPTH));
   assign tag_valid = (count_reg != '0);
   assign pop  = data_computed & tag_valid;
   assign push = s1_valid_reg;

`ifdef CORDIC_PHASE_DITHER_EN
   logic [7:0] lfsr_reg;
   logic       lfsr_fb;

   assign lfsr_fb      = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
   assign sample_phase = acc_reg + {20'd0, lfsr_reg[3:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_reg <= 8'h01;
      end else if (accept) begin
         lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
      end
   end
`else
   assign sample_phase = acc_reg;
`endif

   // Phases in the 0.25..0.75 turn half-plane are mirrored through 0.5 turn; x flips sign there.
   assign fold   = sample_phase[23] ^ sample_phase[22];
   assign r_next = fold ? (24'h800000 - sample_phase) : sample_phase;

   always_comb begin
      acc_next = acc_reg;
      if (phase_load) begin
         acc_next = phase_init;
      end else if (accept) begin
         acc_next = acc_reg + freq;
      end
   end

   always_comb begin
      outstanding_next = outstanding_reg;
      if (accept && !pop) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (!accept && pop) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg         <= '0;
         outstanding_reg <= '0;
      end else begin
         acc_reg         <= acc_next;
         outstanding_reg <= outstanding_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_r_reg     <= '0;
         s1_nx_reg    <= 1'b0;
      end else begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_r_reg  <= r_next;
            s1_nx_reg <= fold;
         end
      end
   end

   // Floor of r * 2pi / 2^24; the folded r is at most a quarter turn so the result fits 24 bits.
   assign prod           = $signed({{24{s1_r_reg[23]}}, s1_r_reg}) * TWO_PI_S;
   assign prod_lo_unused = ^prod[23:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         angle_reg       <= '0;
         data_loaded_reg <= 1'b0;
      end else begin
         data_loaded_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            angle_reg <= prod[47:24];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tag_we
         assign tag_we[gi] = push & (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (tag_we[i]) begin
            tag_mem[i] <= s1_nx_reg;
         end
      end
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (!push && pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         tag_err_reg <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (data_computed && !tag_valid) begin
            tag_err_reg <= 1'b1;
         end
      end
   end

   assign angle       = angle_reg;
   assign data_loaded = data_loaded_reg;
   assign neg_x       = tag_valid & tag_mem[rd_ptr_reg];
   assign tag_err     = tag_err_reg;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed self-checking bench for cordic_phase_gen (default build, no dither).
module tb_cordic_phase_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [23:0] freq = '0;
   logic [23:0] phase_init = '0;
   logic        phase_load = 1'b0;
   logic        data_computed = 1'b0;
   logic [23:0] angle;
   logic        data_loaded;
   logic        neg_x;
   logic        tag_valid;
   logic        tag_err;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [23:0] init;
      logic [23:0] exp_angle;
      logic        exp_nx;
   } vec_t;

   vec_t vecs[12];

   cordic_phase_gen #(.DEPTH(8), .TWO_PI(6588397)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .freq          (freq),
      .phase_init    (phase_init),
      .phase_load    (phase_load),
      .angle         (angle),
      .data_loaded   (data_loaded),
      .data_computed (data_computed),
      .neg_x         (neg_x),
      .tag_valid     (tag_valid),
      .tag_err       (tag_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_angle"}, 32'(angle), 32'h0);
      chk({tag, "_data_loaded"}, 32'(data_loaded), 32'h0);
      chk({tag, "_neg_x"}, 32'(neg_x), 32'h0);
      chk({tag, "_tag_valid"}, 32'(tag_valid), 32'h0);
      chk({tag, "_tag_err"}, 32'(tag_err), 32'h0);
   endtask

   // Load 0, step 1/16 turn per sample with en held; counts strobes seen over a fixed window.
   task automatic fill_run(output int strobes);
      phase_init = 24'h000000;
      phase_load = 1'b1;
      freq       = 24'h100000;
      tick();
      phase_load = 1'b0;
      en         = 1'b1;
      strobes    = 0;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (data_loaded) strobes++;
      end
   endtask

   initial begin
      int strobes;
      logic nx_exp [8];

      vecs[0]  = '{24'h400000, 24'h1921FB, 1'b1};
      vecs[1]  = '{24'hC00000, 24'hE6DE04, 1'b0};
      vecs[2]  = '{24'h800000, 24'h000000, 1'b1};
      vecs[3]  = '{24'h000000, 24'h000000, 1'b0};
      vecs[4]  = '{24'h200000, 24'h0C90FD, 1'b0};
      vecs[5]  = '{24'hE00000, 24'hF36F02, 1'b0};
      vecs[6]  = '{24'h600000, 24'h0C90FD, 1'b1};
      vecs[7]  = '{24'hA00000, 24'hF36F02, 1'b1};
      vecs[8]  = '{24'h7FFFFF, 24'h000000, 1'b1};
      vecs[9]  = '{24'h3FFFFF, 24'h1921FA, 1'b0};
      vecs[10] = '{24'hBFFFFF, 24'hE6DE05, 1'b1};
      vecs[11] = '{24'h100000, 24'h06487E, 1'b0};

      nx_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      #3;
      chk_all_zero("reset");
      #5 rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         phase_init = vecs[i].init;
         phase_load = 1'b1;
         freq       = 24'h0;
         tick();
         phase_load = 1'b0;
         en         = 1'b1;
         tick();
         en = 1'b0;
         chk($sformatf("v%0d_early", i), 32'(data_loaded), 32'h0);
         tick();
         chk($sformatf("v%0d_strobe", i), 32'(data_loaded), 32'h1);
         chk($sformatf("v%0d_angle", i), 32'(angle), 32'(vecs[i].exp_angle));
         chk($sformatf("v%0d_tag_valid", i), 32'(tag_valid), 32'h1);
         chk($sformatf("v%0d_neg_x", i), 32'(neg_x), 32'(vecs[i].exp_nx));
         data_computed = 1'b1;
         tick();
         data_computed = 1'b0;
         chk($sformatf("v%0d_one_shot", i), 32'(data_loaded), 32'h0);
         chk($sformatf("v%0d_hold", i), 32'(angle), 32'(vecs[i].exp_angle));
         chk($sformatf("v%0d_popped", i), 32'(tag_valid), 32'h0);
         $display("vector %0d: phase 0x%06h -> angle 0x%06h neg_x %0b", i, vecs[i].init, angle, vecs[i].exp_nx);
      end

      fill_run(strobes);
      chk("fill_strobes", 32'(strobes), 32'd8);
      chk("fill_last_angle", 32'(angle), 32'h06487E);
      chk("fill_head_nx", 32'(neg_x), 32'h0);
      chk("fill_tag_valid", 32'(tag_valid), 32'h1);
      $display("fill: %0d strobes with credits exhausted", strobes);

      data_computed = 1'b1;
      tick();
      data_computed = 1'b0;
      chk("pop_head_nx", 32'(neg_x), 32'h0);
      tick();
      en = 1'b0;
      chk("resume_early", 32'(data_loaded), 32'h0);
      tick();
      chk("resume_strobe", 32'(data_loaded), 32'h1);
      chk("resume_angle", 32'(angle), 32'h000000);
      tick();
      chk("resume_single", 32'(data_loaded), 32'h0);

      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_valid", i), 32'(tag_valid), 32'h1);
         chk($sformatf("drain%0d_nx", i), 32'(neg_x), 32'(nx_exp[i]));
         data_computed = 1'b1;
         tick();
         data_computed = 1'b0;
         $display("drain %0d: neg_x expected %0b", i, nx_exp[i]);
      end
      chk("drain_empty", 32'(tag_valid), 32'h0);
      chk("drain_no_err", 32'(tag_err), 32'h0);

      data_computed = 1'b1;
      tick();
      data_computed = 1'b0;
      chk("err_set", 32'(tag_err), 32'h1);
      tick();
      tick();
      chk("err_sticky", 32'(tag_err), 32'h1);
      $display("tag_err: pop on empty FIFO");

      phase_init = 24'h400000;
      phase_load = 1'b1;
      freq       = 24'h0;
      tick();
      phase_load = 1'b0;
      en         = 1'b1;
      tick();
      en            = 1'b0;
      data_computed = 1'b1;
      tick();
      data_computed = 1'b0;
      chk("pp_strobe", 32'(data_loaded), 32'h1);
      chk("pp_tag_valid", 32'(tag_valid), 32'h1);
      chk("pp_neg_x", 32'(neg_x), 32'h1);
      chk("pp_angle", 32'(angle), 32'h1921FB);
      data_computed = 1'b1;
      tick();
      data_computed = 1'b0;
      chk("pp_popped", 32'(tag_valid), 32'h0);
      $display("push+pop on empty FIFO");

      phase_init = 24'h000000;
      phase_load = 1'b1;
      freq       = 24'h100000;
      en         = 1'b1;
      tick();
      phase_load = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_pre_strobe", 32'(data_loaded), 32'h1);
      chk("mid_pre_tag_valid", 32'(tag_valid), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      en = 1'b0;
      #3 rst = 1'b1;
      tick();
      chk("mid_post_idle", 32'(data_loaded), 32'h0);
      fill_run(strobes);
      en = 1'b0;
      chk("mid_post_fill", 32'(strobes), 32'd8);
      $display("mid-stream reset: %0d strobes after release", strobes);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
